// File: rtl/mem_port_arbiter_if.sv
// Bundle for mem_port_arbiter: four requester channels plus the byte-wide memory port.
// The master side drives requests and memory read data; the slave side (arbiter) drives the rest.
interface mem_port_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  wide;
    logic [63:0] addr_flat;
    logic [63:0] wdata_flat;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        output req, we, wide, addr_flat, wdata_flat, mem_rdata,
        input  gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, wide, addr_flat, wdata_flat, mem_rdata,
        output gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one byte-wide memory port among store, stack, load and fetch,
// splitting 16-bit accesses into two beats and reassembling read data per requester.
module mem_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned     CntW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    typedef enum logic [0:0] {StArb, StBeat2} state_e;

    typedef struct packed {
        logic       vld;
        logic [1:0] id;
        logic       beat;
        logic       wide;
    } tag_t;

    state_e          state_q;
    logic [CntW-1:0] starve_q;
    logic            mem_en_q;
    logic            mem_we_q;
    logic [15:0]     mem_addr_q;
    logic [7:0]      mem_wdata_q;
    logic [15:0]     beat1_addr_q;
    logic [7:0]      beat1_wdata_q;
    logic            beat1_we_q;
    logic [1:0]      cur_id_q;
    logic            cur_beat_q;
    logic            cur_wide_q;
    tag_t            tag_q [READ_LATENCY];
    logic [7:0]      lo_q;

    logic [3:0]  gnt;
    logic [1:0]  win_id;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_we;
    logic        sel_wide;
    logic        sel_tag_wide;
    tag_t        tag_out;
    logic [3:0]  rvalid;
    logic [15:0] rdata;

    always_comb begin
        gnt = '0;
        if (!rst && state_q == StArb) begin
            if (bus.req[3] && starve_q == StarveMax) gnt = 4'b1000;
            else if (bus.req[0])                     gnt = 4'b0001;
            else if (bus.req[1])                     gnt = 4'b0010;
            else if (bus.req[2])                     gnt = 4'b0100;
            else if (bus.req[3])                     gnt = 4'b1000;
        end
    end

    // Fetch never writes, and its wide accesses return as two independent narrow bytes.
    always_comb begin
        win_id       = '0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_we       = 1'b0;
        sel_wide     = 1'b0;
        sel_tag_wide = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
                win_id       = 2'(i);
                sel_addr     = bus.addr_flat[16*i +: 16];
                sel_wdata    = bus.wdata_flat[16*i +: 16];
                sel_we       = bus.we[i] && (i != 3);
                sel_wide     = bus.wide[i];
                sel_tag_wide = bus.wide[i] && (i != 3);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StArb;
            starve_q      <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            beat1_addr_q  <= '0;
            beat1_wdata_q <= '0;
            beat1_we_q    <= 1'b0;
            cur_id_q      <= '0;
            cur_beat_q    <= 1'b0;
            cur_wide_q    <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;

            if (!bus.req[3] || gnt[3]) starve_q <= '0;
            else if (starve_q != StarveMax) starve_q <= starve_q + 1'b1;

            case (state_q)
                StArb: begin
                    if (|gnt) begin
                        mem_en_q      <= 1'b1;
                        mem_we_q      <= sel_we;
                        mem_addr_q    <= sel_addr;
                        mem_wdata_q   <= sel_wdata[7:0];
                        cur_id_q      <= win_id;
                        cur_beat_q    <= 1'b0;
                        cur_wide_q    <= sel_tag_wide;
                        beat1_addr_q  <= sel_addr + 16'd1;
                        beat1_wdata_q <= sel_wdata[15:8];
                        beat1_we_q    <= sel_we;
                        if (sel_wide) state_q <= StBeat2;
                    end
                end
                StBeat2: begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= beat1_we_q;
                    mem_addr_q  <= beat1_addr_q;
                    mem_wdata_q <= beat1_wdata_q;
                    cur_beat_q  <= 1'b1;
                    state_q     <= StArb;
                end
                default: state_q <= StArb;
            endcase
        end
    end

    // Tags enter alongside the issued read so the last stage lines up with mem_rdata.
    assign tag_out = tag_q[READ_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) tag_q[i] <= '0;
            lo_q <= '0;
        end else begin
            tag_q[0] <= tag_t'{vld: mem_en_q && !mem_we_q, id: cur_id_q, beat: cur_beat_q,
                               wide: cur_wide_q};
            for (int i = 1; i < int'(READ_LATENCY); i++) tag_q[i] <= tag_q[i-1];
            if (tag_out.vld && tag_out.wide && !tag_out.beat) lo_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (tag_out.vld && (!tag_out.wide || tag_out.beat)) begin
            rvalid[tag_out.id] = 1'b1;
            rdata = tag_out.wide ? {bus.mem_rdata, lo_q} : {8'h00, bus.mem_rdata};
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rvalid    = rvalid;
    assign bus.rdata     = rdata;
    assign bus.busy      = (state_q == StBeat2);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT at READ_LATENCY=1, one at READ_LATENCY=3,
// each backed by a small ROM model with a matching read pipeline.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if ifa();
    mem_port_arbiter_if ifb();

    mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    mem_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h1234: rom = 8'hAB;
            16'h2000: rom = 8'h11;
            16'h2001: rom = 8'h22;
            16'h0000: rom = 8'h5A;
            16'h0001: rom = 8'hC3;
            16'h0002: rom = 8'h7E;
            16'h0003: rom = 8'h19;
            default:  rom = a[7:0] ^ a[15:8];
        endcase
    endfunction

    logic [7:0] pipe_a;
    logic [7:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= (ifa.mem_en && !ifa.mem_we) ? rom(ifa.mem_addr) : 8'h00;
        pipe_b[0] <= (ifb.mem_en && !ifb.mem_we) ? rom(ifb.mem_addr) : 8'h00;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign ifa.mem_rdata = pipe_a;
    assign ifb.mem_rdata = pipe_b[2];

    logic [3:0] t3_req [6] = '{4'b1111, 4'b1110, 4'b1100, 4'b1101, 4'b1101, 4'b1001};
    logic [3:0] t3_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0001};
    logic [7:0] t5_byte [4] = '{8'h5A, 8'hC3, 8'h7E, 8'h19};

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int i, input logic r, input logic w, input logic wd,
                           input logic [15:0] ad, input logic [15:0] d);
        ifa.req[i]               = r;
        ifa.we[i]                = w;
        ifa.wide[i]              = wd;
        ifa.addr_flat[16*i +: 16]  = ad;
        ifa.wdata_flat[16*i +: 16] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.req = 4'hF;
        @(negedge clk);
        total_cnt++;
        if ({ifa.gnt, ifa.rvalid, ifa.busy, ifa.mem_en, ifa.mem_we} !== 11'd0)
            $display("FAIL reset_ctrl: got %b want 0",
                     {ifa.gnt, ifa.rvalid, ifa.busy, ifa.mem_en, ifa.mem_we});
        else pass_cnt++;
        total_cnt++;
        if ({ifa.rdata, ifa.mem_addr, ifa.mem_wdata} !== 40'd0)
            $display("FAIL reset_data: got %h want 0", {ifa.rdata, ifa.mem_addr, ifa.mem_wdata});
        else pass_cnt++;
        ifa.req = 4'h0;
        advance();
        rst = 1'b0;
        advance();
    endtask

    task automatic test_narrow_load();
        drive_a(2, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if (ifa.gnt !== 4'b0100) $display("FAIL t1_gnt: got %b want 0100", ifa.gnt);
        else pass_cnt++;
        advance();
        ifa.req = 4'h0;
        @(negedge clk);
        total_cnt++;
        if ({ifa.mem_en, ifa.mem_we, ifa.mem_addr} !== {2'b10, 16'h1234})
            $display("FAIL t1_mem: got en=%b we=%b addr=%h want en=1 we=0 addr=1234",
                     ifa.mem_en, ifa.mem_we, ifa.mem_addr);
        else pass_cnt++;
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.rvalid, ifa.rdata} !== {4'b0100, 16'h00AB})
            $display("FAIL t1_rdata: got rvalid=%b rdata=%h want 0100 00ab", ifa.rvalid, ifa.rdata);
        else pass_cnt++;
        advance();
        @(negedge clk);
        total_cnt++;
        if (ifa.rvalid !== 4'b0000) $display("FAIL t1_rvalid_clr: got %b want 0000", ifa.rvalid);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_wide_push();
        drive_a(1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
        @(negedge clk);
        total_cnt++;
        if ({ifa.gnt, ifa.busy} !== {4'b0010, 1'b0})
            $display("FAIL t2_gnt: got gnt=%b busy=%b want 0010 0", ifa.gnt, ifa.busy);
        else pass_cnt++;
        advance();
        drive_a(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if ({ifa.busy, ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata} !==
            {3'b111, 16'hFFFF, 8'hEF})
            $display("FAIL t2_beat0: got busy=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 ffff ef",
                     ifa.busy, ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata);
        else pass_cnt++;
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.busy, ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, ifa.rvalid} !==
            {3'b011, 16'h0000, 8'hBE, 4'b0000})
            $display("FAIL t2_beat1: got busy=%b en=%b we=%b addr=%h wdata=%h rvalid=%b",
                     ifa.busy, ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, ifa.rvalid);
        else pass_cnt++;
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.mem_en, ifa.rvalid} !== 5'd0)
            $display("FAIL t2_idle: got en=%b rvalid=%b want 0 0000", ifa.mem_en, ifa.rvalid);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_contention();
        drive_a(0, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h0001);
        drive_a(1, 1'b0, 1'b1, 1'b0, 16'h4001, 16'h0002);
        drive_a(2, 1'b0, 1'b0, 1'b0, 16'h4002, 16'h0000);
        drive_a(3, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
        for (int c = 0; c < 6; c++) begin
            ifa.req = t3_req[c];
            @(negedge clk);
            total_cnt++;
            if (ifa.gnt !== t3_gnt[c])
                $display("FAIL t3_gnt_c%0d: got %b want %b", c, ifa.gnt, t3_gnt[c]);
            else pass_cnt++;
            if (c == 5) begin
                total_cnt++;
                if ({ifa.mem_en, ifa.mem_we, ifa.mem_addr} !== {2'b10, 16'h0100})
                    $display("FAIL t3_fetch_mem: got en=%b we=%b addr=%h want 1 0 0100",
                             ifa.mem_en, ifa.mem_we, ifa.mem_addr);
                else pass_cnt++;
            end
            advance();
        end
        ifa.req = 4'h0;
        advance();
        advance();
    endtask

    task automatic test_wide_read_vs_req();
        drive_a(2, 1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if (ifa.gnt !== 4'b0100) $display("FAIL t4_gnt_load: got %b want 0100", ifa.gnt);
        else pass_cnt++;
        advance();
        drive_a(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_a(0, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h0077);
        @(negedge clk);
        total_cnt++;
        if ({ifa.gnt, ifa.busy} !== {4'b0000, 1'b1})
            $display("FAIL t4_beat2_block: got gnt=%b busy=%b want 0000 1", ifa.gnt, ifa.busy);
        else pass_cnt++;
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.gnt, ifa.rvalid, ifa.mem_addr} !== {4'b0001, 4'b0000, 16'h2001})
            $display("FAIL t4_store_gnt: got gnt=%b rvalid=%b addr=%h want 0001 0000 2001",
                     ifa.gnt, ifa.rvalid, ifa.mem_addr);
        else pass_cnt++;
        advance();
        ifa.req = 4'h0;
        @(negedge clk);
        total_cnt++;
        if ({ifa.rvalid, ifa.rdata} !== {4'b0100, 16'h2211})
            $display("FAIL t4_rdata: got rvalid=%b rdata=%h want 0100 2211", ifa.rvalid, ifa.rdata);
        else pass_cnt++;
        total_cnt++;
        if ({ifa.mem_we, ifa.mem_addr, ifa.mem_wdata} !== {1'b1, 16'h3000, 8'h77})
            $display("FAIL t4_store_mem: got we=%b addr=%h wdata=%h want 1 3000 77",
                     ifa.mem_we, ifa.mem_addr, ifa.mem_wdata);
        else pass_cnt++;
        advance();
        advance();
    endtask

    task automatic test_back_to_back();
        drive_a(1, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if (ifa.gnt !== 4'b0010) $display("FAIL b2b_gnt0: got %b want 0010", ifa.gnt);
        else pass_cnt++;
        advance();
        drive_a(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_a(2, 1'b1, 1'b0, 1'b0, 16'h2001, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if (ifa.gnt !== 4'b0100) $display("FAIL b2b_gnt1: got %b want 0100", ifa.gnt);
        else pass_cnt++;
        advance();
        ifa.req = 4'h0;
        @(negedge clk);
        total_cnt++;
        if ({ifa.rvalid, ifa.rdata} !== {4'b0010, 16'h0011})
            $display("FAIL b2b_r0: got rvalid=%b rdata=%h want 0010 0011", ifa.rvalid, ifa.rdata);
        else pass_cnt++;
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.rvalid, ifa.rdata} !== {4'b0100, 16'h0022})
            $display("FAIL b2b_r1: got rvalid=%b rdata=%h want 0100 0022", ifa.rvalid, ifa.rdata);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_fetch_wide();
        drive_a(3, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if (ifa.gnt !== 4'b1000) $display("FAIL fw_gnt: got %b want 1000", ifa.gnt);
        else pass_cnt++;
        advance();
        drive_a(3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.rvalid, ifa.rdata} !== {4'b1000, 16'h005A})
            $display("FAIL fw_r0: got rvalid=%b rdata=%h want 1000 005a", ifa.rvalid, ifa.rdata);
        else pass_cnt++;
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.rvalid, ifa.rdata} !== {4'b1000, 16'h00C3})
            $display("FAIL fw_r1: got rvalid=%b rdata=%h want 1000 00c3", ifa.rvalid, ifa.rdata);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_pipelined_reads();
        ifb.we   = 4'h0;
        ifb.wide = 4'h0;
        for (int c = 0; c < 9; c++) begin
            ifb.req = (c < 4) ? 4'b1000 : 4'b0000;
            ifb.addr_flat[63:48] = 16'(c);
            @(negedge clk);
            if (c < 4) begin
                total_cnt++;
                if ({ifb.gnt, ifb.rvalid} !== {4'b1000, 4'b0000})
                    $display("FAIL t5_gnt_c%0d: got gnt=%b rvalid=%b want 1000 0000",
                             c, ifb.gnt, ifb.rvalid);
                else pass_cnt++;
            end else if (c < 8) begin
                total_cnt++;
                if ({ifb.rvalid, ifb.rdata} !== {4'b1000, 8'h00, t5_byte[c-4]})
                    $display("FAIL t5_rdata_c%0d: got rvalid=%b rdata=%h want 1000 00%h",
                             c, ifb.rvalid, ifb.rdata, t5_byte[c-4]);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (ifb.rvalid !== 4'b0000) $display("FAIL t5_tail: got %b want 0000", ifb.rvalid);
                else pass_cnt++;
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_wide();
        drive_a(2, 1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if (ifa.gnt !== 4'b0100) $display("FAIL t6_gnt: got %b want 0100", ifa.gnt);
        else pass_cnt++;
        advance();
        drive_a(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({ifa.mem_en, ifa.busy, ifa.gnt} !== 6'd0)
            $display("FAIL t6_rst_now: got en=%b busy=%b gnt=%b want 0 0 0000",
                     ifa.mem_en, ifa.busy, ifa.gnt);
        else pass_cnt++;
        advance();
        advance();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({ifa.rvalid, ifa.busy} !== 5'd0)
                $display("FAIL t6_quiet_c%0d: got rvalid=%b busy=%b want 0000 0",
                         c, ifa.rvalid, ifa.busy);
            else pass_cnt++;
            advance();
        end
        drive_a(2, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        @(negedge clk);
        total_cnt++;
        if (ifa.gnt !== 4'b0100) $display("FAIL t6_arb_after: got %b want 0100", ifa.gnt);
        else pass_cnt++;
        advance();
        ifa.req = 4'h0;
        advance();
        @(negedge clk);
        total_cnt++;
        if ({ifa.rvalid, ifa.rdata} !== {4'b0100, 16'h00AB})
            $display("FAIL t6_read_after: got rvalid=%b rdata=%h want 0100 00ab",
                     ifa.rvalid, ifa.rdata);
        else pass_cnt++;
        advance();
    endtask

    initial begin
        rst = 1'b1;
        ifa.req = '0; ifa.we = '0; ifa.wide = '0; ifa.addr_flat = '0; ifa.wdata_flat = '0;
        ifb.req = '0; ifb.we = '0; ifb.wide = '0; ifb.addr_flat = '0; ifb.wdata_flat = '0;
        test_reset();
        test_narrow_load();
        test_wide_push();
        test_contention();
        test_wide_read_vs_req();
        test_back_to_back();
        test_fetch_wide();
        test_pipelined_reads();
        test_reset_mid_wide();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
